// File: rtl/tri_and_gate_sweep_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : tri_and_sweep_pkg                                         |
// | Brief    : Shared types, constants and helpers for the triple        |
// |            3-input AND gate sweep controller.                        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package tri_and_sweep_pkg;

    localparam int NUM_GATES = 3;
    localparam int NUM_VECS  = 8;
    localparam int GATE_W    = 2;
    localparam int VEC_W     = 3;
    localparam int CNT_W     = 4;

    localparam logic [GATE_W-1:0] c_FIRST_GATE = 2'd1;
    localparam logic [GATE_W-1:0] c_LAST_GATE  = 2'd3;
    localparam logic [VEC_W-1:0]  c_LAST_VEC   = 3'd7;

    // Sweep controller states, explicit 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Expected {Y3,Y2,Y1} while gate 'gate' is driven with vector 'vec':
    // only the active gate can be high, and only when all inputs are 1.
    function automatic logic [2:0] expected_outputs(
        input logic [GATE_W-1:0] gate,
        input logic [VEC_W-1:0]  vec
    );
        logic [2:0] exp_y;
        exp_y = 3'b000;
        if (vec == c_LAST_VEC) begin
            case (gate)
                2'd1:    exp_y = 3'b001;
                2'd2:    exp_y = 3'b010;
                2'd3:    exp_y = 3'b100;
                default: exp_y = 3'b000;
            endcase
        end
        return exp_y;
    endfunction

    // Gate input word {A1,B1,C1,A2,B2,C2,A3,B3,C3}: the active gate gets
    // the vector (A as MSB), every other gate is held at 000.
    function automatic logic [8:0] vector_drive(
        input logic [GATE_W-1:0] gate,
        input logic [VEC_W-1:0]  vec
    );
        logic [8:0] word;
        case (gate)
            2'd1:    word = {vec, 6'b000000};
            2'd2:    word = {3'b000, vec, 3'b000};
            2'd3:    word = {6'b000000, vec};
            default: word = 9'd0;
        endcase
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tri_and_gate_sweep_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface: tri_and_gate_sweep_ctrl_if                                |
// | Brief    : Control/status and gate-pin bundle between the sweep      |
// |            controller and its environment (host + gate model).      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface tri_and_gate_sweep_ctrl_if
    import tri_and_sweep_pkg::*;
#(
    parameter int ERR_W = 5
) ();

    // Host request
    logic              start;
    // Gate outputs under test
    logic              Y1;
    logic              Y2;
    logic              Y3;
    // Registered gate inputs
    logic              A1;
    logic              B1;
    logic              C1;
    logic              A2;
    logic              B2;
    logic              C2;
    logic              A3;
    logic              B3;
    logic              C3;
    // Status / results
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_count;
    logic [GATE_W-1:0] fail_gate;
    logic [VEC_W-1:0]  fail_vec;

    // Controller side
    modport slave (
        input  start, Y1, Y2, Y3,
        output A1, B1, C1, A2, B2, C2, A3, B3, C3,
        output busy, done, pass, err_count, fail_gate, fail_vec
    );

    // Environment side (host plus gate under test)
    modport master (
        output start, Y1, Y2, Y3,
        input  A1, B1, C1, A2, B2, C2, A3, B3, C3,
        input  busy, done, pass, err_count, fail_gate, fail_vec
    );

endinterface
`default_nettype wire

// File: rtl/tri_and_gate_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tri_and_gate_sweep_ctrl                                   |
// | Brief    : Walks all 8 input vectors on each gate of a triple        |
// |            3-input AND gate, waits a settle time, checks the three   |
// |            outputs and reports pass/fail, error count and the first  |
// |            failing vector.                                           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tri_and_gate_sweep_ctrl
    import tri_and_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 5
) (
    input wire clk,
    input wire reset,
    tri_and_gate_sweep_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] c_SETTLE  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] c_ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    // Registered state and outputs
    state_t            r_state;
    logic [GATE_W-1:0] r_gate;
    logic [VEC_W-1:0]  r_vec;
    logic [CNT_W-1:0]  r_cnt;
    logic [8:0]        r_in;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [ERR_W-1:0]  r_err;
    logic [GATE_W-1:0] r_fail_gate;
    logic [VEC_W-1:0]  r_fail_vec;

    // Next-state values
    state_t            w_state_nxt;
    logic [GATE_W-1:0] w_gate_nxt;
    logic [VEC_W-1:0]  w_vec_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [8:0]        w_in_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_pass_nxt;
    logic [ERR_W-1:0]  w_err_nxt;
    logic [GATE_W-1:0] w_fail_gate_nxt;
    logic [VEC_W-1:0]  w_fail_vec_nxt;

    // Compare path
    logic [2:0]        w_exp_y;
    logic [2:0]        w_miss;
    logic [ERR_W-1:0]  w_err_sat;
    logic [GATE_W-1:0] w_first_miss;
    logic              w_last_vec;

    assign w_exp_y    = expected_outputs(r_gate, r_vec);
    assign w_miss     = {bus.Y3, bus.Y2, bus.Y1} ^ w_exp_y;
    // Error count sticks at all-ones instead of wrapping back to a "pass".
    assign w_err_sat  = (&r_err) ? r_err : (r_err + c_ERR_ONE);
    assign w_last_vec = (r_gate == c_LAST_GATE) && (r_vec == c_LAST_VEC);

    // Lowest-numbered mismatching output; only used when w_miss is non-zero.
    always_comb begin
        w_first_miss = 2'd3;
        if (w_miss[0]) begin
            w_first_miss = 2'd1;
        end else if (w_miss[1]) begin
            w_first_miss = 2'd2;
        end
    end

    // State register plus all registered outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gate      <= '0;
            r_vec       <= '0;
            r_cnt       <= '0;
            r_in        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= '0;
            r_fail_gate <= '0;
            r_fail_vec  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gate      <= w_gate_nxt;
            r_vec       <= w_vec_nxt;
            r_cnt       <= w_cnt_nxt;
            r_in        <= w_in_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_err       <= w_err_nxt;
            r_fail_gate <= w_fail_gate_nxt;
            r_fail_vec  <= w_fail_vec_nxt;
        end
    end

    // Next-state and next-output decode for the sweep sequence.
    always_comb begin
        w_state_nxt     = r_state;
        w_gate_nxt      = r_gate;
        w_vec_nxt       = r_vec;
        w_cnt_nxt       = r_cnt;
        w_in_nxt        = r_in;
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done;
        w_pass_nxt      = r_pass;
        w_err_nxt       = r_err;
        w_fail_gate_nxt = r_fail_gate;
        w_fail_vec_nxt  = r_fail_vec;

        case (r_state)
            IDLE, DONE: begin
                // A new sweep clears the previous results and drives the
                // first vector on the same edge that raises busy.
                if (bus.start) begin
                    w_state_nxt     = WAIT;
                    w_gate_nxt      = c_FIRST_GATE;
                    w_vec_nxt       = '0;
                    w_in_nxt        = vector_drive(c_FIRST_GATE, '0);
                    w_cnt_nxt       = c_SETTLE;
                    w_busy_nxt      = 1'b1;
                    w_done_nxt      = 1'b0;
                    w_pass_nxt      = 1'b1;
                    w_err_nxt       = '0;
                    w_fail_gate_nxt = '0;
                    w_fail_vec_nxt  = '0;
                end
            end

            WAIT: begin
                // Counter runs SETTLE..0, giving SETTLE+1 wait cycles.
                if (r_cnt == '0) begin
                    w_state_nxt = CHECK;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end

            CHECK: begin
                if (|w_miss) begin
                    w_err_nxt  = w_err_sat;
                    w_pass_nxt = 1'b0;
                    // fail_gate == 0 means nothing has been latched yet.
                    if (r_fail_gate == '0) begin
                        w_fail_gate_nxt = w_first_miss;
                        w_fail_vec_nxt  = r_vec;
                    end
                end

                if (w_last_vec) begin
                    w_in_nxt    = '0;
                    w_state_nxt = DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    if (r_vec == c_LAST_VEC) begin
                        w_vec_nxt  = '0;
                        w_gate_nxt = r_gate + 2'd1;
                    end else begin
                        w_vec_nxt = r_vec + 3'd1;
                    end
                    w_in_nxt    = vector_drive(w_gate_nxt, w_vec_nxt);
                    w_cnt_nxt   = c_SETTLE;
                    w_state_nxt = WAIT;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.A1        = r_in[8];
    assign bus.B1        = r_in[7];
    assign bus.C1        = r_in[6];
    assign bus.A2        = r_in[5];
    assign bus.B2        = r_in[4];
    assign bus.C2        = r_in[3];
    assign bus.A3        = r_in[2];
    assign bus.B3        = r_in[1];
    assign bus.C3        = r_in[0];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err;
    assign bus.fail_gate = r_fail_gate;
    assign bus.fail_vec  = r_fail_vec;

endmodule
`default_nettype wire

// File: tb/tb_tri_and_gate_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_tri_and_gate_sweep_ctrl                                |
// | Brief    : Three controller instances (settle 2 / err width 5,       |
// |            settle 2 / err width 3, settle 0 / err width 5) driving   |
// |            a behavioural triple AND gate with injectable faults.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_tri_and_gate_sweep_ctrl;

    localparam int SWEEP_WIN = 110;

    logic clk = 1'b0;
    logic reset;
    logic start;

    // Fault injection: per-output stuck-at masks (bit0 = Y1) and a table of
    // output flips keyed by the full 9-bit gate input word.
    logic [2:0] s1;
    logic [2:0] s0;
    logic [2:0] xtbl [0:511];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tri_and_gate_sweep_ctrl_if #(.ERR_W(5)) ifa ();
    tri_and_gate_sweep_ctrl_if #(.ERR_W(3)) ifb ();
    tri_and_gate_sweep_ctrl_if #(.ERR_W(5)) ifc ();

    tri_and_gate_sweep_ctrl #(.SETTLE_CYCLES(2), .ERR_W(5)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    tri_and_gate_sweep_ctrl #(.SETTLE_CYCLES(2), .ERR_W(3)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
    tri_and_gate_sweep_ctrl #(.SETTLE_CYCLES(0), .ERR_W(5)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

    logic [8:0] w_word [3];
    logic [2:0] y_obs  [3];
    logic       m_busy [3];
    logic       m_done [3];
    logic       m_pass [3];
    logic [4:0] m_err  [3];
    logic [1:0] m_fg   [3];
    logic [2:0] m_fv   [3];

    assign w_word[0] = {ifa.A1, ifa.B1, ifa.C1, ifa.A2, ifa.B2, ifa.C2, ifa.A3, ifa.B3, ifa.C3};
    assign w_word[1] = {ifb.A1, ifb.B1, ifb.C1, ifb.A2, ifb.B2, ifb.C2, ifb.A3, ifb.B3, ifb.C3};
    assign w_word[2] = {ifc.A1, ifc.B1, ifc.C1, ifc.A2, ifc.B2, ifc.C2, ifc.A3, ifc.B3, ifc.C3};

    // Behavioural 74LS11 (zero delay) with the fault overlay.
    assign y_obs[0] = (({&w_word[0][2:0], &w_word[0][5:3], &w_word[0][8:6]} | s1) & ~s0) ^ xtbl[w_word[0]];
    assign y_obs[1] = (({&w_word[1][2:0], &w_word[1][5:3], &w_word[1][8:6]} | s1) & ~s0) ^ xtbl[w_word[1]];
    assign y_obs[2] = (({&w_word[2][2:0], &w_word[2][5:3], &w_word[2][8:6]} | s1) & ~s0) ^ xtbl[w_word[2]];

    assign ifa.Y1 = y_obs[0][0];
    assign ifa.Y2 = y_obs[0][1];
    assign ifa.Y3 = y_obs[0][2];
    assign ifb.Y1 = y_obs[1][0];
    assign ifb.Y2 = y_obs[1][1];
    assign ifb.Y3 = y_obs[1][2];
    assign ifc.Y1 = y_obs[2][0];
    assign ifc.Y2 = y_obs[2][1];
    assign ifc.Y3 = y_obs[2][2];
    assign ifa.start = start;
    assign ifb.start = start;
    assign ifc.start = start;

    assign m_busy[0] = ifa.busy;
    assign m_busy[1] = ifb.busy;
    assign m_busy[2] = ifc.busy;
    assign m_done[0] = ifa.done;
    assign m_done[1] = ifb.done;
    assign m_done[2] = ifc.done;
    assign m_pass[0] = ifa.pass;
    assign m_pass[1] = ifb.pass;
    assign m_pass[2] = ifc.pass;
    assign m_err[0]  = ifa.err_count;
    assign m_err[1]  = {2'b00, ifb.err_count};
    assign m_err[2]  = ifc.err_count;
    assign m_fg[0]   = ifa.fail_gate;
    assign m_fg[1]   = ifb.fail_gate;
    assign m_fg[2]   = ifc.fail_gate;
    assign m_fv[0]   = ifa.fail_vec;
    assign m_fv[1]   = ifb.fail_vec;
    assign m_fv[2]   = ifc.fail_vec;

    // Per-sweep observations gathered by run_sweep
    int   obs_busy    [3];
    int   obs_done_at [3];
    int   obs_trace   [3];
    logic obs_k0_busy [3];
    logic obs_k0_done [3];

    function automatic int settle_of(input int d);
        return (d == 2) ? 0 : 2;
    endfunction

    function automatic int errw_of(input int d);
        return (d == 1) ? 3 : 5;
    endfunction

    // Sweep length in cycles: 24 vectors, each SETTLE+1 waits plus a check.
    function automatic int len_of(input int d);
        return 24 * (settle_of(d) + 2);
    endfunction

    // Input word for sweep step idx (0..23): gate idx/8, vector idx%8.
    function automatic logic [8:0] pat_of(input int idx);
        int g0;
        int v;
        g0 = idx / 8;
        v  = idx % 8;
        return 9'(v) << (3 * (2 - g0));
    endfunction

    function automatic logic [2:0] gate_obs(input logic [8:0] p);
        logic [2:0] t;
        t = {&p[2:0], &p[5:3], &p[8:6]};
        return ((t | s1) & ~s0) ^ xtbl[p];
    endfunction

    // Reference: count failing vectors over the whole sweep from the rules.
    task automatic ref_sweep(input int errw, output int err, output int fg, output int fv);
        err = 0;
        fg  = 0;
        fv  = 0;
        for (int idx = 0; idx < 24; idx++) begin
            logic [2:0] want;
            logic [2:0] got;
            want = (idx % 8 == 7) ? 3'(1 << (idx / 8)) : 3'b000;
            got  = gate_obs(pat_of(idx));
            if (got != want) begin
                err++;
                if (fg == 0) begin
                    fv = idx % 8;
                    for (int b = 2; b >= 0; b--) if (got[b] != want[b]) fg = b + 1;
                end
            end
        end
        if (err > (1 << errw) - 1) err = (1 << errw) - 1;
    endtask

    task automatic clear_faults();
        s1 = 3'b000;
        s0 = 3'b000;
        for (int i = 0; i < 512; i++) xtbl[i] = 3'b000;
    endtask

    task automatic randomize_faults();
        int n;
        clear_faults();
        if ($urandom_range(0, 3) == 0) s1 = 3'($urandom_range(1, 7));
        if ($urandom_range(0, 3) == 0) s0 = 3'($urandom_range(1, 7));
        n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++) begin
            logic [8:0] p;
            p = pat_of($urandom_range(0, 23));
            xtbl[p] = xtbl[p] ^ 3'($urandom_range(1, 7));
        end
    endtask

    // Start all three controllers together; keep start high for 'hold'
    // further sampled cycles, then watch busy/done and the input trace.
    task automatic run_sweep(input int hold);
        for (int d = 0; d < 3; d++) begin
            obs_busy[d]    = 0;
            obs_done_at[d] = -1;
            obs_trace[d]   = 0;
        end
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < SWEEP_WIN; k++) begin
            @(negedge clk);
            if (k >= hold) start = 1'b0;
            for (int d = 0; d < 3; d++) begin
                logic [8:0] want;
                want = (k < len_of(d)) ? pat_of(k / (settle_of(d) + 2)) : 9'd0;
                if (k == 0) begin
                    obs_k0_busy[d] = m_busy[d];
                    obs_k0_done[d] = m_done[d];
                end
                if (m_busy[d]) obs_busy[d]++;
                if (m_done[d] && obs_done_at[d] < 0) obs_done_at[d] = k;
                if (w_word[d] !== want) obs_trace[d]++;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        clear_faults();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            n_tests++; if (w_word[d] !== 9'd0) begin n_fail++; $display("FAIL reset_inputs dut%0d: got %h want 000", d, w_word[d]); end
            n_tests++; if ({m_busy[d], m_done[d], m_pass[d], m_err[d], m_fg[d], m_fv[d]} !== 13'd0) begin n_fail++; $display("FAIL reset_status dut%0d: busy=%0b done=%0b pass=%0b err=%0d fg=%0d fv=%0d want all 0", d, m_busy[d], m_done[d], m_pass[d], m_err[d], m_fg[d], m_fv[d]); end
        end
        reset = 1'b0;
    endtask

    task automatic test_good_sweep();
        clear_faults();
        run_sweep(0);
        for (int d = 0; d < 3; d++) begin
            n_tests++; if (obs_k0_busy[d] !== 1'b1) begin n_fail++; $display("FAIL good_busy_at_t0 dut%0d: got %0b want 1", d, obs_k0_busy[d]); end
            n_tests++; if (obs_busy[d] !== len_of(d)) begin n_fail++; $display("FAIL good_busy_cycles dut%0d: got %0d want %0d", d, obs_busy[d], len_of(d)); end
            n_tests++; if (obs_done_at[d] !== len_of(d)) begin n_fail++; $display("FAIL good_done_cycle dut%0d: got %0d want %0d", d, obs_done_at[d], len_of(d)); end
            n_tests++; if (obs_trace[d] !== 0) begin n_fail++; $display("FAIL good_vector_trace dut%0d: got %0d bad cycles want 0", d, obs_trace[d]); end
            n_tests++; if ({m_done[d], m_pass[d]} !== 2'b11) begin n_fail++; $display("FAIL good_done_pass dut%0d: got done=%0b pass=%0b want 1/1", d, m_done[d], m_pass[d]); end
            n_tests++; if ({m_err[d], m_fg[d]} !== 7'd0) begin n_fail++; $display("FAIL good_err_fg dut%0d: got err=%0d fg=%0d want 0/0", d, m_err[d], m_fg[d]); end
        end
    endtask

    task automatic test_stuck_y2();
        clear_faults();
        s1 = 3'b010;
        run_sweep(0);
        for (int d = 0; d < 3; d++) begin
            int want_err;
            want_err = (d == 1) ? 7 : 23;
            n_tests++; if (int'(m_err[d]) !== want_err) begin n_fail++; $display("FAIL y2_err_count dut%0d: got %0d want %0d", d, m_err[d], want_err); end
            n_tests++; if (m_fg[d] !== 2'd2 || m_fv[d] !== 3'd0) begin n_fail++; $display("FAIL y2_first_fail dut%0d: got gate=%0d vec=%0d want 2/0", d, m_fg[d], m_fv[d]); end
            n_tests++; if ({m_done[d], m_pass[d]} !== 2'b10) begin n_fail++; $display("FAIL y2_done_pass dut%0d: got done=%0b pass=%0b want 1/0", d, m_done[d], m_pass[d]); end
            n_tests++; if (obs_done_at[d] !== len_of(d)) begin n_fail++; $display("FAIL y2_done_cycle dut%0d: got %0d want %0d", d, obs_done_at[d], len_of(d)); end
        end
    endtask

    task automatic test_stuck_y3();
        clear_faults();
        s0 = 3'b100;
        run_sweep(0);
        for (int d = 0; d < 3; d++) begin
            n_tests++; if (int'(m_err[d]) !== 1) begin n_fail++; $display("FAIL y3_err_count dut%0d: got %0d want 1", d, m_err[d]); end
            n_tests++; if (m_fg[d] !== 2'd3 || m_fv[d] !== 3'd7) begin n_fail++; $display("FAIL y3_first_fail dut%0d: got gate=%0d vec=%0d want 3/7", d, m_fg[d], m_fv[d]); end
            n_tests++; if (m_pass[d] !== 1'b0) begin n_fail++; $display("FAIL y3_pass dut%0d: got %0b want 0", d, m_pass[d]); end
        end
    endtask

    task automatic test_start_ignored();
        clear_faults();
        run_sweep(40);
        for (int d = 0; d < 3; d++) begin
            n_tests++; if (obs_done_at[d] !== len_of(d)) begin n_fail++; $display("FAIL hold_done_cycle dut%0d: got %0d want %0d", d, obs_done_at[d], len_of(d)); end
            n_tests++; if (obs_busy[d] !== len_of(d)) begin n_fail++; $display("FAIL hold_busy_cycles dut%0d: got %0d want %0d", d, obs_busy[d], len_of(d)); end
            n_tests++; if (obs_trace[d] !== 0) begin n_fail++; $display("FAIL hold_vector_trace dut%0d: got %0d bad cycles want 0", d, obs_trace[d]); end
        end
    endtask

    // Each sweep starts from DONE of the previous one with fresh random faults.
    task automatic test_back_to_back();
        for (int it = 0; it < 6; it++) begin
            int e [3];
            int f [3];
            int v [3];
            randomize_faults();
            for (int d = 0; d < 3; d++) ref_sweep(errw_of(d), e[d], f[d], v[d]);
            run_sweep(0);
            for (int d = 0; d < 3; d++) begin
                n_tests++; if (obs_k0_busy[d] !== 1'b1 || obs_k0_done[d] !== 1'b0) begin n_fail++; $display("FAIL b2b_restart it%0d dut%0d: got busy=%0b done=%0b want 1/0", it, d, obs_k0_busy[d], obs_k0_done[d]); end
                n_tests++; if (obs_done_at[d] !== len_of(d)) begin n_fail++; $display("FAIL b2b_done_cycle it%0d dut%0d: got %0d want %0d", it, d, obs_done_at[d], len_of(d)); end
                n_tests++; if (int'(m_err[d]) !== e[d]) begin n_fail++; $display("FAIL b2b_err_count it%0d dut%0d: got %0d want %0d", it, d, m_err[d], e[d]); end
                n_tests++; if (int'(m_fg[d]) !== f[d] || (f[d] != 0 && int'(m_fv[d]) !== v[d])) begin n_fail++; $display("FAIL b2b_first_fail it%0d dut%0d: got gate=%0d vec=%0d want %0d/%0d", it, d, m_fg[d], m_fv[d], f[d], v[d]); end
                n_tests++; if (m_pass[d] !== (e[d] == 0)) begin n_fail++; $display("FAIL b2b_pass it%0d dut%0d: got %0b want %0b", it, d, m_pass[d], e[d] == 0); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic saw_done [3];
        clear_faults();
        s1 = 3'b010;
        for (int d = 0; d < 3; d++) saw_done[d] = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 150; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 40) reset = 1'b1;
            if (k == 41) begin
                for (int d = 0; d < 3; d++) begin
                    n_tests++; if ({w_word[d], m_busy[d], m_done[d], m_pass[d], m_err[d], m_fg[d], m_fv[d]} !== 22'd0) begin n_fail++; $display("FAIL midreset_outputs dut%0d: got in=%h busy=%0b done=%0b pass=%0b err=%0d fg=%0d fv=%0d want all 0", d, w_word[d], m_busy[d], m_done[d], m_pass[d], m_err[d], m_fg[d], m_fv[d]); end
                end
                reset = 1'b0;
            end
            if (k > 41) for (int d = 0; d < 3; d++) if (m_done[d] || m_busy[d]) saw_done[d] = 1'b1;
        end
        for (int d = 0; d < 3; d++) begin
            n_tests++; if (saw_done[d] !== 1'b0) begin n_fail++; $display("FAIL midreset_stays_idle dut%0d: got busy/done activity=1 want 0", d); end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_good_sweep();
        test_stuck_y2();
        test_stuck_y3();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tri_and_gate_sweep_ctrl.md
# tri_and_gate_sweep_ctrl

Self-checking sequencer for a triple 3-input AND gate (74LS11 model, `tri_3_input_and_gate`). On `start`, it walks all 8 input combinations on gate 1, then gate 2, then gate 3. For each vector it waits a programmable settle time, samples all three outputs and compares them against the expected values. It sits between a lab-board controller (or bench) and the gate model, and reports pass/fail, an error count and the first failing vector.

## Interface

Parameters:
- `SETTLE_CYCLES`, default 2: extra wait cycles after applying a vector before sampling; legal range 0..15.
- `ERR_W`, default 5: width of `err_count`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a sweep; honoured only in IDLE or DONE.
- `Y1`, `Y2`, `Y3` in 1 each: gate outputs under test.
- `A1`, `B1`, `C1`, `A2`, `B2`, `C2`, `A3`, `B3`, `C3` out 1 each: registered gate inputs.
- `busy` out 1: high in WAIT and CHECK.
- `done` out 1: high in DONE.
- `pass` out 1: valid while `done`; 1 when `err_count == 0`.
- `err_count` out ERR_W: number of failing vectors; saturates at all-ones.
- `fail_gate` out 2: lowest-numbered mismatching output (1..3) of the first failing vector; 0 means no failure.
- `fail_vec` out 3: vector index of the first failure.

## Operation

- The FSM has four states: IDLE, WAIT, CHECK and DONE.
- Vector encoding: index v drives {A,B,C} = v, with A as the MSB. Gates are swept in the order g = 1, 2, 3, and v runs 0..7 within each gate. This gives 24 vectors in total.
- While gate g is active, the other gates' inputs are held at 000.
- Expected outputs: Yg = (v == 7); every idle gate's output = 0.
- **IDLE or DONE, `start` = 1:**
  - Clear `err_count`, `fail_gate` and `fail_vec`.
  - Set g = 1, v = 0 and drive the vector.
  - Load the settle counter with SETTLE_CYCLES and go to WAIT.
- **WAIT:** if the counter is 0, go to CHECK; otherwise decrement the counter.
- **CHECK:** compare {Y1,Y2,Y3} with the expected outputs.
  - On any mismatch, increment `err_count` (saturating). If this is the first failure, latch `fail_gate` and `fail_vec`.
  - If g = 3 and v = 7: drive all inputs to 0 and go to DONE.
  - Otherwise: advance v, wrapping to the next g after 7. Drive the new vector, reload the counter and go to WAIT.
- **DONE:** hold all results until `start` or `reset`.
- `start` in WAIT or CHECK is ignored.
- `reset` at any time, including mid-sweep, takes effect at the next edge:
  - state goes to IDLE;
  - all gate inputs go to 0;
  - `busy`, `done`, `pass`, `err_count`, `fail_gate` and `fail_vec` go to 0.

## Timing

- All outputs are registered. Reset value of every output is 0.
- `start` sampled at edge t0 → at t0 `busy` = 1 and the first vector is driven.
- Each vector occupies SETTLE_CYCLES+1 WAIT cycles plus 1 CHECK cycle.
- DONE is entered at edge t0 + 24·(SETTLE_CYCLES+2). With the default, that is t0 + 96; with SETTLE_CYCLES = 0, t0 + 48.
- The Y inputs are sampled at the CHECK→next edge. The gate's `Delay` must be below (SETTLE_CYCLES+1) clock periods.
- `start` in DONE: `done` drops and `busy` rises at the same edge.
- `pass` and the failure fields change only in CHECK, at reset, or at a start-clear.

## Structure

- Shared package `tri_and_sweep_pkg` holds:
  - the state encoding (IDLE, WAIT, CHECK, DONE);
  - constants NUM_GATES = 3 and NUM_VECS = 8;
  - the expected-output function (g, v) → 3-bit.
- No sub-module. Vector decode, compare and counters are local to the block. The bench instantiates `tri_3_input_and_gate` separately.

## Test plan

- **Good sweep:** correct gate (`Delay` 0), SETTLE_CYCLES = 2; reset, then `start` pulse → `busy` high for exactly 96 cycles, then `done` = 1, `pass` = 1, `err_count` = 0, `fail_gate` = 0.
- **Stuck-at-1 on Y2:** bench forces Y2 = 1 → 23 failing vectors (gate 1: 8, gate 2: v0..6, gate 3: 8). Expect `err_count` = 23, `fail_gate` = 2, `fail_vec` = 0, `pass` = 0. Repeat with ERR_W = 3 → `err_count` saturates at 7.
- **Stuck-at-0 on Y3:** only gate 3, v = 7 fails → `err_count` = 1, `fail_gate` = 3, `fail_vec` = 7.
- **Start handling:** `start` held high mid-sweep → no restart, DONE still at cycle 96. `start` in DONE → counters cleared and a new 96-cycle sweep runs.
- **Reset mid-sweep:** assert `reset` at cycle 40 → next edge all 15 outputs are 0, state IDLE, and no `done` follows.
- **SETTLE_CYCLES = 0:** DONE at t0 + 48, with each vector visible on A/B/C for exactly 2 cycles.
